// File: rtl/sp_fifo_ctrl.sv
// Stream FIFO controller for an external single-port synchronous RAM.
// Writes and reads share the RAM port; read data is staged through a 2-entry output queue.
module sp_fifo_ctrl #(
  parameter int AWIDTH = 8,
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DWIDTH-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DWIDTH-1:0] m_data,
  output logic              mem_wr,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [DWIDTH-1:0] mem_wdata,
  input  logic [DWIDTH-1:0] mem_rdata,
  output logic [AWIDTH+1:0] count
);

  localparam int DEPTH = 1 << AWIDTH;
  localparam logic [AWIDTH:0]   CNT_FULL = (AWIDTH+1)'(DEPTH);
  localparam logic [AWIDTH:0]   CNT_ONE  = (AWIDTH+1)'(1);
  localparam logic [AWIDTH-1:0] PTR_ONE  = AWIDTH'(1);

  logic [AWIDTH-1:0] r_wr_ptr;
  logic [AWIDTH-1:0] r_rd_ptr;
  logic [AWIDTH:0]   r_ram_cnt;
  logic              r_rd_pend;
  logic              r_prio;
  logic [1:0]        r_oq_cnt;
  logic [DWIDTH-1:0] r_oq_head;
  logic [DWIDTH-1:0] r_oq_tail;

  logic [1:0] w_inflight;
  logic       w_wreq;
  logic       w_rreq;
  logic       w_conflict;
  logic       w_grant_wr;
  logic       w_grant_rd;
  logic       w_push;
  logic       w_pop;

  // Requests are gated by rst_n so no RAM cycle is granted while reset is held.
  assign w_inflight = r_oq_cnt + {1'b0, r_rd_pend};
  assign w_wreq     = rst_n && s_valid && (r_ram_cnt != CNT_FULL);
  assign w_rreq     = rst_n && (r_ram_cnt != '0) && (w_inflight < 2'd2);
  assign w_conflict = w_wreq && w_rreq;
  assign w_grant_wr = w_wreq && (!w_rreq || !r_prio);
  assign w_grant_rd = w_rreq && (!w_wreq || r_prio);

  assign mem_wr    = w_grant_wr;
  assign s_ready   = w_grant_wr;
  assign mem_addr  = w_grant_wr ? r_wr_ptr : r_rd_ptr;
  assign mem_wdata = s_data;

  assign w_push  = r_rd_pend;
  assign m_valid = (r_oq_cnt != 2'd0);
  assign w_pop   = m_valid && m_ready;
  assign m_data  = r_oq_head;
  assign count   = (AWIDTH+2)'(r_ram_cnt) + (AWIDTH+2)'(r_rd_pend) + (AWIDTH+2)'(r_oq_cnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_ram_cnt <= '0;
      r_rd_pend <= 1'b0;
      r_prio    <= 1'b0;
    end else begin
      if (w_grant_wr) begin
        r_wr_ptr  <= r_wr_ptr + PTR_ONE;
        r_ram_cnt <= r_ram_cnt + CNT_ONE;
      end else if (w_grant_rd) begin
        r_rd_ptr  <= r_rd_ptr + PTR_ONE;
        r_ram_cnt <= r_ram_cnt - CNT_ONE;
      end
      r_rd_pend <= w_grant_rd;
      if (w_conflict) begin
        r_prio <= ~r_prio;
      end
    end
  end

  // Output queue: head is what m_data shows, tail holds the second word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_oq_cnt  <= 2'd0;
      r_oq_head <= '0;
      r_oq_tail <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b11: begin
          if (r_oq_cnt == 2'd1) begin
            r_oq_head <= mem_rdata;
          end else begin
            r_oq_head <= r_oq_tail;
            r_oq_tail <= mem_rdata;
          end
        end
        2'b10: begin
          if (r_oq_cnt == 2'd0) begin
            r_oq_head <= mem_rdata;
          end else begin
            r_oq_tail <= mem_rdata;
          end
          r_oq_cnt <= r_oq_cnt + 2'd1;
        end
        2'b01: begin
          r_oq_head <= r_oq_tail;
          r_oq_cnt  <= r_oq_cnt - 2'd1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sp_fifo_ctrl.sv
// Bench for sp_fifo_ctrl with a behavioural RAM and a word-queue scoreboard (AWIDTH=3).
module tb_sp_fifo_ctrl;

  localparam int AW    = 3;
  localparam int DW    = 32;
  localparam int DEPTH = 1 << AW;

  logic          clk;
  logic          rst_n;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic [AW+1:0] count;

  sp_fifo_ctrl #(.AWIDTH(AW), .DWIDTH(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .mem_wr    (mem_wr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port synchronous RAM: write, or registered read.
  logic [DW-1:0] ram [DEPTH];
  initial mem_rdata = '0;
  always @(posedge clk) begin
    if (mem_wr) ram[mem_addr] <= mem_wdata;
    else        mem_rdata <= ram[mem_addr];
  end

  int            n_assert = 0;
  int            n_fail   = 0;
  logic [DW-1:0] sb [$];
  int            wcnt = 0;
  int            cyc  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: the FIFO holds exactly the accepted-but-not-yet-delivered words, in order.
  task automatic cyc_begin();
    logic [DW-1:0] exp_w;
    @(negedge clk);
    chk("count", count, sb.size());
    chk("count_bound", count <= DEPTH + 2, 1);
    chk("wr_eq_ready", mem_wr, s_ready);
    if (!s_valid) chk("ready_without_valid", s_ready, 0);
    if (sb.size() == DEPTH + 2) chk("full_blocks_write", s_ready, 0);
    if (m_valid && m_ready) begin
      if (sb.size() == 0) begin
        chk("pop_when_empty", m_valid, 0);
      end else begin
        exp_w = sb.pop_front();
        chk("pop_data", m_data, exp_w);
      end
    end
    if (s_valid && s_ready) begin
      chk("wr_addr", mem_addr, wcnt % DEPTH);
      chk("wr_data", mem_wdata, s_data);
      sb.push_back(s_data);
      wcnt++;
    end
  endtask

  task automatic cyc_end();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic cycle();
    cyc_begin();
    cyc_end();
  endtask

  task automatic drain(input string tag, input int limit);
    s_valid = 1'b0;
    m_ready = 1'b1;
    for (int i = 0; i < limit && sb.size() > 0; i++) cycle();
    chk(tag, sb.size(), 0);
    cycle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  acc;
    int  first_c;
    int  last_c;
    bit  took;
    bit  got;

    // Reset held with active inputs
    rst_n   = 1'b0;
    s_valid = 1'b1;
    m_ready = 1'b1;
    s_data  = '1;
    #12;
    chk("rst_mem_wr", mem_wr, 0);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_m_data", m_data, 0);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    m_ready = 1'b0;
    rst_n   = 1'b1;

    // Idle
    repeat (20) begin
      cyc_begin();
      chk("idle_mem_wr", mem_wr, 0);
      chk("idle_count", count, 0);
      cyc_end();
    end

    // Single word latency
    s_valid = 1'b1;
    s_data  = 32'hDEADBEEF;
    m_ready = 1'b1;
    cyc_begin();
    chk("c0_mem_wr", mem_wr, 1);
    chk("c0_addr", mem_addr, 0);
    chk("c0_s_ready", s_ready, 1);
    cyc_end();
    s_valid = 1'b0;
    cyc_begin();
    chk("c1_mem_wr", mem_wr, 0);
    chk("c1_addr", mem_addr, 0);
    chk("c1_m_valid", m_valid, 0);
    cyc_end();
    cyc_begin();
    chk("c2_m_valid", m_valid, 0);
    cyc_end();
    cyc_begin();
    chk("c3_m_valid", m_valid, 1);
    chk("c3_m_data", m_data, 32'hDEADBEEF);
    cyc_end();
    cyc_begin();
    chk("c4_count", count, 0);
    cyc_end();

    // Fill with consumer stalled: capacity is DEPTH+2
    m_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 12; i++) begin
      s_valid = 1'b1;
      s_data  = DW'(i);
      took    = 1'b0;
      for (int t = 0; t < 30 && !took; t++) begin
        cyc_begin();
        took = s_ready;
        if (i >= DEPTH + 2) chk("fill_ready_low", s_ready, 0);
        cyc_end();
      end
      if (took) acc++;
    end
    s_valid = 1'b0;
    chk("fill_accepted", acc, DEPTH + 2);
    cyc_begin();
    chk("fill_count", count, DEPTH + 2);
    cyc_end();
    drain("fill_drain_done", 100);

    // Concurrent streaming, both sides always ready
    s_valid = 1'b1;
    m_ready = 1'b1;
    s_data  = 32'd100;
    acc     = 0;
    first_c = -1;
    last_c  = -1;
    for (int t = 0; t < 400 && acc < 40; t++) begin
      cyc_begin();
      took = s_valid && s_ready;
      if (took) begin
        if (first_c < 0) first_c = cyc;
        last_c = cyc;
      end
      cyc_end();
      if (took) begin
        acc++;
        s_data = 32'd100 + DW'(acc);
        if (acc == 40) s_valid = 1'b0;
      end
    end
    chk("stream_accepted", acc, 40);
    chk("stream_alternates", (last_c - first_c >= 74) && (last_c - first_c <= 80), 1);
    drain("stream_drain_done", 100);

    // Random backpressure
    acc     = 0;
    s_valid = 1'b1;
    m_ready = 1'b0;
    s_data  = $urandom;
    for (int t = 0; t < 20000 && acc < 1000; t++) begin
      cyc_begin();
      took = s_valid && s_ready;
      cyc_end();
      if (took) begin
        acc++;
        s_data = $urandom;
      end
      s_valid = (acc < 1000) && ($urandom_range(3) != 0);
      m_ready = ($urandom_range(2) != 0);
    end
    chk("random_accepted", acc, 1000);
    drain("random_drain_done", 200);

    // Reset while a read is in flight
    s_valid = 1'b1;
    s_data  = 32'h00000ABC;
    m_ready = 1'b0;
    cycle();
    s_valid = 1'b0;
    cycle();
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_m_valid", m_valid, 0);
    chk("midrst_count", count, 0);
    chk("midrst_mem_wr", mem_wr, 0);
    chk("midrst_m_data", m_data, 0);
    sb.delete();
    wcnt = 0;
    @(posedge clk);
    #1;
    chk("midrst_hold_m_valid", m_valid, 0);
    chk("midrst_hold_count", count, 0);
    #1;
    rst_n   = 1'b1;
    s_valid = 1'b1;
    s_data  = 32'h1;
    m_ready = 1'b1;
    got     = 1'b0;
    for (int t = 0; t < 20 && !got; t++) begin
      cyc_begin();
      if (m_valid) begin
        chk("post_rst_first_word", m_data, 32'h1);
        got = 1'b1;
      end
      took = s_valid && s_ready;
      cyc_end();
      if (took) s_valid = 1'b0;
    end
    chk("post_rst_word_seen", got, 1);
    drain("post_rst_drain_done", 50);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
